// File: rtl/myuart_rx_pkg.sv
// myuart_rx shared definitions
// state encoding, frame geometry, parity sense
package myuart_rx_pkg;

  localparam int DATA_W    = 8;
  localparam int OS_FACTOR = 16;
  localparam int TICK_W    = $clog2(OS_FACTOR);
  localparam int BIT_W     = $clog2(DATA_W);

  // 1 = odd parity, 0 = even parity
  localparam bit PARITY_ODD = 1'b1;

  localparam logic [TICK_W-1:0] MID_TICK  =
    TICK_W'(OS_FACTOR / 2 - 1);
  localparam logic [TICK_W-1:0] LAST_TICK =
    TICK_W'(OS_FACTOR - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  =
    BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  function automatic logic parity_bad(
    input logic [DATA_W-1:0] d,
    input logic              p
  );
    return ((^d) ^ p) != PARITY_ODD;
  endfunction

endpackage

// File: rtl/myuart_os_tick.sv
// myuart oversample tick generator
// one pulse every DIV enabled clocks
module myuart_os_tick
  import myuart_rx_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic os_tick
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OS_FACTOR);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // restart holds the divider at zero so the first
  // tick of a frame lands DIV clocks after release
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (enable) begin
      if (restart || cnt == LAST) cnt <= '0;
      else                        cnt <= cnt + 1'b1;
    end
  end

  // tick is qualified so nothing fires while held
  always_comb begin
    os_tick = enable && !restart && (cnt == LAST);
  end

endmodule

// File: rtl/myuart_rx.sv
// myuart receiver: 8 data, odd parity, 1 stop
// 16x oversampling, mid-bit sampling
module myuart_rx
  import myuart_rx_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              rx_data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ack,
  output logic              parity_error,
  output logic              frame_error,
  output logic              overrun,
  output logic              rx_busy
);

  rx_state_t         state;
  rx_state_t         next_state;
  logic              sync1;
  logic              rx_sync;
  logic              os_tick;
  logic [TICK_W-1:0] tick_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              par_bit;
  logic              at_mid;
  logic              sample_data;
  logic              sample_par;
  logic              complete;

  myuart_os_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_os_tick (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .restart (state == IDLE),
    .os_tick (os_tick)
  );

  // two-flop synchronizer, idles high
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1   <= 1'b1;
      rx_sync <= 1'b1;
    end else if (enable) begin
      sync1   <= rx_data_in;
      rx_sync <= sync1;
    end
  end

  // state register
  always_ff @(posedge clock) begin
    if (reset)       state <= IDLE;
    else if (enable) state <= next_state;
  end

  // next state and sample strobes
  always_comb begin
    next_state  = state;
    sample_data = 1'b0;
    sample_par  = 1'b0;
    complete    = 1'b0;
    at_mid      = os_tick && (tick_cnt ==
      ((state == START) ? MID_TICK : LAST_TICK));
    unique case (state)
      IDLE:
        if (!rx_sync) next_state = START;
      START:
        if (at_mid) next_state = rx_sync ? IDLE : DATA;
      DATA:
        if (at_mid) begin
          sample_data = 1'b1;
          if (bit_cnt == LAST_BIT) next_state = PARITY;
        end
      PARITY:
        if (at_mid) begin
          sample_par = 1'b1;
          next_state = STOP;
        end
      STOP:
        if (at_mid) begin
          complete   = 1'b1;
          next_state = rx_sync ? IDLE : BREAK;
        end
      BREAK:
        if (rx_sync) next_state = IDLE;
      default:
        next_state = IDLE;
    endcase
  end

  // tick and bit counters, cleared while idle
  always_ff @(posedge clock) begin
    if (reset) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else if (enable) begin
      if (state == IDLE) begin
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else begin
        if (os_tick)
          tick_cnt <= at_mid ? '0 : tick_cnt + 1'b1;
        if (sample_data)
          bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // LSB-first shift register and parity capture
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_reg <= '0;
      par_bit   <= 1'b0;
    end else if (enable) begin
      if (sample_data)
        shift_reg <= {rx_sync, shift_reg[DATA_W-1:1]};
      if (sample_par)
        par_bit <= rx_sync;
    end
  end

  // output byte and status flags; an ack in the
  // completion cycle consumes the old byte only
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out     <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
    end else if (enable) begin
      if (complete) begin
        data_out     <= shift_reg;
        data_valid   <= 1'b1;
        parity_error <= parity_bad(shift_reg, par_bit);
        frame_error  <= !rx_sync;
        if (data_ack)        overrun <= 1'b0;
        else if (data_valid) overrun <= 1'b1;
      end else if (data_ack) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

  // busy whenever a frame or break is in progress
  always_comb begin
    rx_busy = (state != IDLE);
  end

endmodule

// File: tb/tb_myuart_rx.sv
// myuart_rx bench: directed frames plus random bytes
// against a frame-level model of the receiver
module tb_myuart_rx;

  localparam int BIT_CLKS = 160;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       rx_data_in = 1'b1;
  logic       data_ack = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       frame_error;
  logic       overrun;
  logic       rx_busy;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] m_data = '0;
  logic       m_valid = 1'b0;
  logic       m_pe = 1'b0;
  logic       m_fe = 1'b0;
  logic       m_ovr = 1'b0;

  myuart_rx #(
    .CLK_FREQ  (1600000),
    .BAUD_RATE (10000)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .rx_data_in   (rx_data_in),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .data_ack     (data_ack),
    .parity_error (parity_error),
    .frame_error  (frame_error),
    .overrun      (overrun),
    .rx_busy      (rx_busy)
  );

  always #5 clock = ~clock;

  task automatic check1(input string tag,
                        input logic obs,
                        input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b",
             tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag,
                        input logic [7:0] obs,
                        input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_data_in = b;
    clks(BIT_CLKS);
  endtask

  task automatic check_all(input string tag,
                           input logic busy);
    check8({tag, ".data"}, data_out, m_data);
    check1({tag, ".valid"}, data_valid, m_valid);
    check1({tag, ".perr"}, parity_error, m_pe);
    check1({tag, ".ferr"}, frame_error, m_fe);
    check1({tag, ".ovr"}, overrun, m_ovr);
    check1({tag, ".busy"}, rx_busy, busy);
  endtask

  task automatic do_ack();
    data_ack = 1'b1;
    clks(1);
    data_ack = 1'b0;
    m_valid = 1'b0;
    m_ovr = 1'b0;
  endtask

  // mid-stop sample is 83 clocks into the stop bit;
  // ack_mid strobes data_ack onto exactly that edge
  task automatic send_frame(input logic [7:0] d,
                            input logic p,
                            input logic s,
                            input logic ack_mid);
    logic pre_valid;
    pre_valid = m_valid;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    rx_data_in = s;
    for (int i = 0; i < BIT_CLKS; i++) begin
      @(posedge clock);
      #1;
      data_ack = ack_mid && (i == 81);
      if (i == 78)
        check1("lat_pre", data_valid, pre_valid);
      if (i == 84)
        check1("lat_post", data_valid, 1'b1);
    end
    if (ack_mid)      m_ovr = 1'b0;
    else if (m_valid) m_ovr = 1'b1;
    m_valid = 1'b1;
    m_data  = d;
    m_pe    = (($countones(d) + int'(p)) % 2) == 0;
    m_fe    = !s;
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  initial begin
    logic [7:0] rd;
    logic       rp;

    clks(5);
    check_all("in_reset", 1'b0);
    reset = 1'b0;
    clks(3);
    check_all("post_reset", 1'b0);

    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    check_all("a5", 1'b0);
    do_ack();
    check_all("a5_ack", 1'b0);

    send_frame(8'h01, 1'b1, 1'b1, 1'b0);
    check_all("bad_par", 1'b0);
    do_ack();

    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    check_all("stop0", 1'b1);
    clks(BIT_CLKS);
    check1("break_hold", rx_busy, 1'b1);
    rx_data_in = 1'b1;
    clks(10);
    check1("break_exit", rx_busy, 1'b0);
    do_ack();
    send_frame(8'h00, 1'b1, 1'b1, 1'b0);
    check_all("after_break", 1'b0);
    do_ack();

    rx_data_in = 1'b0;
    clks(40);
    rx_data_in = 1'b1;
    clks(10);
    check1("glitch_busy", rx_busy, 1'b1);
    clks(40);
    check1("glitch_idle", rx_busy, 1'b0);
    check1("glitch_valid", data_valid, m_valid);
    clks(200);

    send_frame(8'h11, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1, 1'b0);
    check_all("overrun", 1'b0);
    do_ack();
    check_all("overrun_ack", 1'b0);

    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b1, 1'b1);
    check_all("ack_same", 1'b0);
    do_ack();

    send_frame(8'h81, 1'b1, 1'b1, 1'b0);
    enable = 1'b0;
    data_ack = 1'b1;
    clks(5);
    data_ack = 1'b0;
    check1("enable_hold", data_valid, 1'b1);
    enable = 1'b1;
    do_ack();
    check_all("enable_ack", 1'b0);

    rd = 8'h5B;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(rd[i]);
    rx_data_in = rd[4];
    clks(80);
    reset = 1'b1;
    clks(2);
    reset = 1'b0;
    rx_data_in = 1'b1;
    m_data = '0;
    m_valid = 1'b0;
    m_pe = 1'b0;
    m_fe = 1'b0;
    m_ovr = 1'b0;
    clks(2 * BIT_CLKS);
    check_all("abort", 1'b0);
    send_frame(8'h7E, 1'b1, 1'b1, 1'b0);
    check_all("after_abort", 1'b0);

    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 1) == 1) do_ack();
      rd = 8'($urandom);
      rp = odd_par(rd);
      if ($urandom_range(0, 3) == 0) rp = !rp;
      send_frame(rd, rp, 1'b1, 1'b0);
      check_all("rand", 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/myuart_rx.md
MYUART_RX -- requirements
Module: myuart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, serial bit rate in bit/s.
REQ-003 clock  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 enable  input  1  when low, all state, counters and outputs hold.
REQ-006 rx_data_in  input  1  asynchronous serial line, idle high.
REQ-007 data_out  output  8  last received data byte.
REQ-008 data_valid  output  1  data_out holds an unread byte.
REQ-009 data_ack  input  1  consumer read strobe; clears data_valid.
REQ-010 parity_error  output  1  parity check result of the last completed frame.
REQ-011 frame_error  output  1  stop-bit error of the last completed frame.
REQ-012 overrun  output  1  sticky flag: a frame completed while data_valid was high.
REQ-013 rx_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 Frame format SHALL be: 1 start bit (0), 8 data bits LSB first, 1 odd-parity bit (the count of ones in data plus parity is odd), 1 stop bit (1).
REQ-015 rx_data_in SHALL pass through a 2-flop synchronizer before use; both flops reset to 1.
REQ-016 The oversample tick SHALL pulse once every DIV = floor(CLK_FREQ/(BAUD_RATE*16)) enabled clocks, giving 16 ticks per bit.
REQ-017 The oversample divider SHALL restart from zero when the FSM leaves IDLE.
REQ-018 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP and BREAK.
REQ-019 IDLE: a synchronized low SHALL cause a transition to START and clear the tick count.
REQ-020 START: on the 8th tick (mid-bit), a sampled 1 SHALL return the FSM to IDLE (false start, no outputs change); a sampled 0 SHALL move it to DATA.
REQ-021 DATA: each bit SHALL be sampled every 16th tick after mid-start and shifted in LSB first; after 8 bits the FSM SHALL move to PARITY.
REQ-022 PARITY: the parity bit SHALL be sampled at mid-bit, then the FSM SHALL move to STOP.
REQ-023 STOP: at mid-stop-bit sample the FSM SHALL, on the same edge, load data_out, set data_valid, and update parity_error and frame_error (frame_error = sampled stop bit is 0).
REQ-024 STOP: after that sample the FSM SHALL go to IDLE if the stop bit was 1, otherwise to BREAK.
REQ-025 BREAK: the FSM SHALL wait for a synchronized 1, then go to IDLE.
REQ-026 If data_valid is already high and not being acked at frame completion, data_out SHALL still be overwritten and overrun SHALL be set.
REQ-027 data_ack SHALL clear data_valid and overrun on the next edge.
REQ-028 If data_ack and frame completion occur in the same cycle, data_valid SHALL remain 1 and overrun SHALL not be set.
REQ-029 Latency from the mid-stop-bit tick to data_valid high SHALL be one clock.
REQ-030 A reset asserted mid-frame SHALL abort the frame with no data_valid pulse.

Reset
REQ-031 On reset: FSM = IDLE, divider = 0, tick count = 0, bit count = 0, shift register = 0x00.
REQ-032 On reset: data_out = 0x00 and data_valid, parity_error, frame_error, overrun, rx_busy are all 0.
REQ-033 On reset: synchronizer flops = 1.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, the data width (8), the oversample factor (16) and the parity-sense constant (odd).
REQ-035 One sub-module, myuart_os_tick (parameters CLK_FREQ, BAUD_RATE; ports clock, reset, enable, restart, os_tick), SHALL generate the oversample tick.
REQ-036 The synchronizer, FSM, bit counter, shift register and flags SHALL remain in myuart_rx.

Verification (CLK_FREQ=1600000, BAUD_RATE=10000: DIV=10, 160 clocks/bit)
REQ-037 Frame 0xA5 with parity 1 and stop 1 -> data_out=0xA5, data_valid=1, parity_error=0, frame_error=0.
REQ-038 Frame 0x01 with parity 1 (wrong) -> data_out=0x01, parity_error=1.
REQ-039 Frame 0x3C with parity 1 and stop 0, line held low for 2 bit times -> frame_error=1; FSM stays in BREAK until the line returns high; the next valid frame 0x00/parity 1 -> errors cleared.
REQ-040 40-clock low glitch on an idle line -> false start; no data_valid; rx_busy returns to 0 by about clock 85.
REQ-041 Two back-to-back frames 0x11 then 0x22 with no data_ack -> data_out=0x22, overrun=1; data_ack then clears both data_valid and overrun.
REQ-042 reset pulsed during data bit 4, then frame 0x7E with parity 1 -> no output from the aborted frame; data_out=0x7E.
